// File: rtl/pipe_trace_buffer.sv
// Trace capture buffer: records qualified probe words with cycle stamps between
// a programmable start and end cycle, in linear or ring mode, then pops oldest-first.
module pipe_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       arm_i,
  input  logic                       mode_i,
  input  logic [CNT_W-1:0]           start_cycle_i,
  input  logic [CNT_W-1:0]           end_count_i,
  input  logic                       trig_i,
  input  logic                       trace_valid_i,
  input  logic [DATA_W-1:0]          trace_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [CNT_W-1:0]           rd_stamp_o,
  output logic                       rd_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic [CNT_W-1:0]           cycle_o,
  output logic [1:0]                 state_o,
  output logic                       overflow_o,
  output logic                       done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_FROZEN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic              mode_q;
  logic [CNT_W-1:0]  start_q, end_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  rd_stamp_q;
  logic              rd_valid_q;

  logic              wr_en;
  logic              pop;
  logic              full;
  logic              end_hit;
  logic [CNT_W-1:0]  cycle_inc;

  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [CNT_W-1:0]  mem_stamp [DEPTH];

  assign full      = (count_q == FULL_CNT);
  assign end_hit   = (end_q != '0) && (cycle_q == end_q);
  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    wr_en      = 1'b0;
    pop        = 1'b0;

    if (arm_i) begin
      state_d    = (start_cycle_i == '0) ? S_CAPTURE : S_WAIT;
      cycle_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          cycle_d = cycle_inc;
          // End beats start, so end_count < start_cycle freezes with nothing held.
          if (end_hit) begin
            state_d = S_FROZEN;
            done_d  = 1'b1;
          end else if (cycle_q == start_q - 1'b1) begin
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          cycle_d = cycle_inc;
          if (trace_valid_i && (mode_q || !full)) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (full) begin
              rd_ptr_d   = rd_ptr_q + 1'b1;
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
          if (end_hit || (mode_q && trig_i) ||
              (!mode_q && wr_en && (count_q == FULL_CNT - 1'b1))) begin
            state_d = S_FROZEN;
          end
          if (end_hit) done_d = 1'b1;
        end
        S_FROZEN: begin
          if (rd_en_i && (count_q != '0)) begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cycle_q    <= '0;
      mode_q     <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_stamp_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      rd_valid_q <= pop;
      if (arm_i) begin
        mode_q  <= mode_i;
        start_q <= start_cycle_i;
        end_q   <= end_count_i;
      end
      if (pop) begin
        rd_data_q  <= mem_data[rd_ptr_q];
        rd_stamp_q <= mem_stamp[rd_ptr_q];
      end
    end
  end

  // NOTE: the storage array has no reset; count and pointers define which
  // entries are meaningful, so clearing them is enough to discard contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_data[wr_ptr_q]  <= trace_data_i;
      mem_stamp[wr_ptr_q] <= cycle_q;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_stamp_o = rd_stamp_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);
  assign cycle_o    = cycle_q;
  assign state_o    = state_q;
  assign overflow_o = overflow_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer: pops push expected words into a queue,
// a negedge monitor compares each rd_valid_o beat against it, including timing.
module tb_pipe_trace_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arm = 1'b0;
  logic              mode = 1'b0;
  logic [CNT_W-1:0]  start_cycle = '0;
  logic [CNT_W-1:0]  end_count = '0;
  logic              trig = 1'b0;
  logic              trace_valid = 1'b0;
  logic [DATA_W-1:0] trace_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  rd_stamp;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              empty;
  logic [CNT_W-1:0]  cycle;
  logic [1:0]        state;
  logic              overflow;
  logic              done;

  pipe_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .mode_i(mode),
    .start_cycle_i(start_cycle), .end_count_i(end_count), .trig_i(trig),
    .trace_valid_i(trace_valid), .trace_data_i(trace_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_stamp_o(rd_stamp), .rd_valid_o(rd_valid),
    .count_o(count), .empty_o(empty), .cycle_o(cycle), .state_o(state),
    .overflow_o(overflow), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  stamp;
    int                due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat must match the queue head and arrive on its due cycle.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: rd_valid_o=1 data=%0d with nothing expected", rd_data);
      end else begin
        mon_e = sb.pop_front();
        check("pop_data", rd_data, mon_e.data);
        check("pop_stamp", 32'(rd_stamp), 32'(mon_e.stamp));
        check("pop_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_pop: rd_valid_o=0, expected data %0d stamp %0d", mon_e.data, mon_e.stamp);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic arm_run(input logic m, input int s, input int e);
    mode        = m;
    start_cycle = CNT_W'(s);
    end_count   = CNT_W'(e);
    arm         = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drive valid samples (data = cycle + off) until FROZEN or budget runs out.
  task automatic run_capture(input int off, input bit odd_only, input int trig_at, input int budget);
    int n = 0;
    while (state != 2'd3 && n < budget) begin
      trace_valid = odd_only ? cycle[0] : 1'b1;
      trace_data  = 32'(cycle) + 32'(off);
      trig        = (trig_at >= 0) && (int'(cycle) == trig_at);
      tick();
      n++;
    end
    trace_valid = 1'b0;
    trig        = 1'b0;
    check("reach_frozen", 32'(state), 3);
  endtask

  task automatic pop_seq(input int n, input int off, input int stamp0, input int stride);
    for (int i = 0; i < n; i++) begin
      int st;
      st = stamp0 + i * stride;
      sb.push_back('{data: 32'(st + off), stamp: CNT_W'(st), due: cyc + 1});
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_cycle", 32'(cycle), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_flags", {30'd0, overflow, done}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_stamp", 32'(rd_stamp), 0);
    rst = 1'b0;
    tick();

    // 1: linear, start 3, captures cycles 3..18, data 103..118
    arm_run(1'b0, 3, 0);
    check("t1_wait_state", 32'(state), 1);
    check("t1_first_cycle", 32'(cycle), 0);
    run_capture(100, 1'b0, -1, 60);
    check("t1_count", 32'(count), 16);
    check("t1_overflow", 32'(overflow), 0);
    check("t1_done", 32'(done), 0);
    pop_seq(16, 100, 3, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t1_pop17_valid", 32'(rd_valid), 0);
    check("t1_empty", 32'(empty), 1);

    // 2: ring, trig at 40 keeps 25..40
    arm_run(1'b1, 0, 0);
    check("t2_capture_state", 32'(state), 2);
    run_capture(0, 1'b0, 40, 100);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_count", 32'(count), 16);
    check("t2_done", 32'(done), 0);
    pop_seq(16, 0, 25, 1);

    // 3a: end count 5 after start 2
    arm_run(1'b0, 2, 5);
    run_capture(200, 1'b0, -1, 50);
    check("t3a_done", 32'(done), 1);
    check("t3a_count", 32'(count), 4);
    pop_seq(4, 200, 2, 1);

    // 3b: end 1 before start 4, freezes from WAIT empty
    arm_run(1'b0, 4, 1);
    run_capture(0, 1'b0, -1, 50);
    check("t3b_done", 32'(done), 1);
    check("t3b_count", 32'(count), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3b_empty_pop", 32'(rd_valid), 0);

    // 4: odd cycles only, end 10, back-to-back readout
    arm_run(1'b0, 0, 10);
    run_capture(300, 1'b1, -1, 50);
    check("t4_count", 32'(count), 5);
    check("t4_done", 32'(done), 1);
    pop_seq(5, 300, 1, 2);

    // 5: reset mid-capture with 7 entries
    arm_run(1'b0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      trace_valid = 1'b1;
      trace_data  = 32'(cycle) + 700;
      tick();
    end
    trace_valid = 1'b0;
    check("t5_pre_count", 32'(count), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_state", 32'(state), 0);
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_flags", {29'd0, overflow, done, rd_valid}, 0);
    trace_valid = 1'b1;
    rd_en       = 1'b1;
    repeat (3) tick();
    trace_valid = 1'b0;
    rd_en       = 1'b0;
    check("t5_idle_state", 32'(state), 0);
    check("t5_idle_count", 32'(count), 0);
    check("t5_idle_cycle", 32'(cycle), 0);

    // 5b: re-arm from FROZEN with entries and overflow set
    arm_run(1'b1, 0, 0);
    run_capture(800, 1'b0, 20, 60);
    check("t5b_overflow", 32'(overflow), 1);
    arm_run(1'b0, 1, 0);
    check("t5b_rearm_state", 32'(state), 1);
    check("t5b_rearm_count", 32'(count), 0);
    check("t5b_rearm_flags", {30'd0, overflow, done}, 0);
    run_capture(500, 1'b0, -1, 60);
    check("t5b_count", 32'(count), 16);
    pop_seq(2, 500, 1, 1);
    check("t5b_after_pops", 32'(count), 14);

    // 6: rd_en during CAPTURE ignored; trig coincides with end
    arm_run(1'b1, 0, 5);
    for (int i = 0; i < 2; i++) begin
      trace_valid = 1'b1;
      trace_data  = 32'(cycle) + 600;
      tick();
    end
    trace_data = 32'(cycle) + 600;
    rd_en      = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t6_capture_count", 32'(count), 3);
    check("t6_capture_rd_valid", 32'(rd_valid), 0);
    run_capture(600, 1'b0, 5, 50);
    check("t6_done", 32'(done), 1);
    check("t6_count", 32'(count), 6);
    check("t6_overflow", 32'(overflow), 0);
    pop_seq(6, 600, 0, 1);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
